// File: rtl/cpu_run_controller.sv
// Single-clock run controller for the CPU core: power-on reset hold, run/halt,
// single-step and PC breakpoint, emitting a one-cycle clock-enable strobe.
module cpu_run_controller #(
  parameter int SLOW_DIV_BITS     = 26,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int PC_WIDTH          = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_btn,
  input  logic                step_btn,
  input  logic                halt_sw,
  input  logic                slow_sw,
  input  logic                cpu_halt_req,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                bp_enable,
  input  logic [PC_WIDTH-1:0] bp_addr,
  output logic                cpu_clk_en,
  output logic                cpu_rst,
  output logic [1:0]          state,
  output logic                bp_hit,
  output logic [31:0]         cycle_count
);

  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_HALTED     = 2'd1,
    ST_RUNNING    = 2'd2,
    ST_STEP       = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic                     cpu_rst_q, cpu_rst_d;
  logic                     clk_en_q, clk_en_d;
  logic                     bp_hit_q, bp_hit_d;
  logic [31:0]              cycle_q, cycle_d;
  logic [SLOW_DIV_BITS-1:0] div_q, div_d;
  logic                     run_prev_q, run_prev_d;
  logic                     step_prev_q, step_prev_d;
  logic                     skip_bp_q, skip_bp_d;

  logic run_edge;
  logic step_edge;
  logic tick;
  logic bp_match;

  assign run_edge  = run_btn & ~run_prev_q;
  assign step_edge = step_btn & ~step_prev_q;
  assign tick      = slow_sw ? (&div_q) : 1'b1;
  // skip_bp lets a resumed run step over the address it stopped on
  assign bp_match  = bp_enable & (pc == bp_addr) & ~skip_bp_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    clk_en_d    = 1'b0;
    bp_hit_d    = bp_hit_q;
    skip_bp_d   = skip_bp_q;
    div_d       = div_q + 1'b1;
    run_prev_d  = run_btn;
    step_prev_d = step_btn;
    cycle_d     = cycle_q + {31'd0, clk_en_q};

    case (state_q)
      ST_RESET_HOLD: begin
        if (hold_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_HALTED: begin
        if (step_edge) begin
          state_d = ST_STEP;
        end else if (run_edge && !halt_sw && !cpu_halt_req) begin
          state_d   = ST_RUNNING;
          bp_hit_d  = 1'b0;
          skip_bp_d = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (halt_sw || cpu_halt_req) begin
          state_d = ST_HALTED;
        end else if (tick) begin
          if (bp_match) begin
            state_d  = ST_HALTED;
            bp_hit_d = 1'b1;
          end else begin
            clk_en_d  = 1'b1;
            skip_bp_d = 1'b0;
          end
        end
      end
      ST_STEP: begin
        clk_en_d = 1'b1;
        state_d  = ST_HALTED;
      end
      default: state_d = ST_RESET_HOLD;
    endcase

    cpu_rst_d = (state_d == ST_RESET_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESET_HOLD;
      hold_q      <= HOLD_INIT;
      cpu_rst_q   <= 1'b1;
      clk_en_q    <= 1'b0;
      bp_hit_q    <= 1'b0;
      cycle_q     <= '0;
      div_q       <= '0;
      run_prev_q  <= 1'b0;
      step_prev_q <= 1'b0;
      skip_bp_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cpu_rst_q   <= cpu_rst_d;
      clk_en_q    <= clk_en_d;
      bp_hit_q    <= bp_hit_d;
      cycle_q     <= cycle_d;
      div_q       <= div_d;
      run_prev_q  <= run_prev_d;
      step_prev_q <= step_prev_d;
      skip_bp_q   <= skip_bp_d;
    end
  end

  assign cpu_clk_en  = clk_en_q;
  assign cpu_rst     = cpu_rst_q;
  assign state       = state_q;
  assign bp_hit      = bp_hit_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: strobe timing is checked against a
// queue of expected strobe cycles, state/counters by immediate assertions.
module tb_cpu_run_controller;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_btn = 1'b0;
  logic          step_btn = 1'b0;
  logic          halt_sw = 1'b0;
  logic          slow_sw = 1'b0;
  logic          cpu_halt_req = 1'b0;
  logic          bp_enable = 1'b0;
  logic [PW-1:0] bp_addr = '0;
  logic          cpu_clk_en;
  logic          cpu_rst;
  logic [1:0]    state;
  logic          bp_hit;
  logic [31:0]   cycle_count;

  logic          pc_clr = 1'b1;
  logic [PW-1:0] pc_m = '0;
  logic [2:0]    div_m;
  int            cyc = 0;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  cpu_run_controller #(
    .SLOW_DIV_BITS(3),
    .RESET_HOLD_CYCLES(4),
    .PC_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run_btn(run_btn),
    .step_btn(step_btn),
    .halt_sw(halt_sw),
    .slow_sw(slow_sw),
    .cpu_halt_req(cpu_halt_req),
    .pc(pc_m),
    .bp_enable(bp_enable),
    .bp_addr(bp_addr),
    .cpu_clk_en(cpu_clk_en),
    .cpu_rst(cpu_rst),
    .state(state),
    .bp_hit(bp_hit),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Free-running divider model, cleared by reset like the controller's.
  always @(posedge clk or posedge rst) begin
    if (rst) div_m <= '0;
    else     div_m <= div_m + 3'd1;
  end

  // CPU model: program counter advances on every enabled clock.
  always @(posedge clk) begin
    if (pc_clr)          pc_m <= '0;
    else if (cpu_clk_en) pc_m <= pc_m + 16'd1;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each strobe must match the next expected cycle.
  always @(negedge clk) begin : monitor
    int e;
    if (cpu_clk_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", cyc, -1);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", cyc, e);
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release rst and follow the hold sequence: 4 cycles of cpu_rst then HALTED.
  task automatic release_seq();
    rst = 1'b0;
    pc_clr = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      $display("hold step %0d: cpu_rst=%0d state=%0d", i, cpu_rst, state);
      chk("hold_cpu_rst", cpu_rst, (i < 4) ? 1 : 0);
      chk("hold_state", state, (i < 4) ? 0 : 1);
      chk("hold_clk_en", cpu_clk_en, 0);
      chk("hold_count", cycle_count, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pc_clr = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_clk_en", cpu_clk_en, 0);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_count", cycle_count, 0);
    wait_neg(3);
    release_seq();
  endtask

  // First slow-tick interval once RUNNING starts at interval k+1.
  function automatic int first_tick(input int k, input logic [2:0] d);
    int off;
    off = (7 - int'(d)) & 7;
    if (off == 0) off = 8;
    return k + off;
  endfunction

  initial begin
    int k;
    int j;

    // Reset
    do_reset();

    // Fast run, then halt after exactly 10 strobes
    @(negedge clk);
    k = cyc;
    run_btn = 1'b1;
    for (int i = 2; i <= 11; i++) exp_q.push_back(k + i);
    $display("fast run: run edge at cycle %0d", k);
    @(negedge clk);
    run_btn = 1'b0;
    #1 chk("run_state", state, 2);
    wait_neg(10);
    halt_sw = 1'b1;
    wait_neg(3);
    #1;
    $display("fast halt: count=%0d state=%0d", cycle_count, state);
    chk("halt_count", cycle_count, 10);
    chk("halt_state", state, 1);
    chk("halt_clk_en", cpu_clk_en, 0);
    chk("halt_drain", exp_q.size(), 0);

    // Run pulse under halt_sw is ignored and not remembered
    @(negedge clk);
    run_btn = 1'b1;
    @(negedge clk);
    run_btn = 1'b0;
    wait_neg(3);
    #1 chk("run_blocked_state", state, 1);
    @(negedge clk);
    halt_sw = 1'b0;
    wait_neg(3);
    #1;
    $display("run under halt: state=%0d count=%0d", state, cycle_count);
    chk("run_forgot_state", state, 1);
    chk("run_forgot_count", cycle_count, 10);

    // Single step
    do_reset();
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      k = cyc;
      step_btn = 1'b1;
      exp_q.push_back(k + 2);
      @(negedge clk);
      step_btn = 1'b0;
      #1 chk("step_entry_state", state, 3);
      @(negedge clk);
      #1;
      $display("step %0d: state=%0d clk_en=%0d", p, state, cpu_clk_en);
      chk("step_exit_state", state, 1);
      chk("step_strobe", cpu_clk_en, 1);
      wait_neg(3);
    end
    #1 chk("step_count", cycle_count, 3);

    // Simultaneous run and step edges: step wins, one strobe only
    @(negedge clk);
    k = cyc;
    run_btn = 1'b1;
    step_btn = 1'b1;
    exp_q.push_back(k + 2);
    @(negedge clk);
    run_btn = 1'b0;
    step_btn = 1'b0;
    wait_neg(4);
    #1;
    $display("run+step: state=%0d count=%0d", state, cycle_count);
    chk("both_state", state, 1);
    chk("both_count", cycle_count, 4);
    chk("both_drain", exp_q.size(), 0);

    // Breakpoint at 0x0005, slow ticks so pc settles between ticks
    slow_sw = 1'b1;
    bp_enable = 1'b1;
    bp_addr = 16'h0005;
    do_reset();
    @(negedge clk);
    k = cyc;
    j = first_tick(k, div_m);
    run_btn = 1'b1;
    for (int m = 0; m < 5; m++) exp_q.push_back(j + 1 + 8 * m);
    @(negedge clk);
    run_btn = 1'b0;
    wait_neg(j + 43 - (k + 1));
    #1;
    $display("bp halt: pc=%0d bp_hit=%0d count=%0d state=%0d", pc_m, bp_hit, cycle_count, state);
    chk("bp_state", state, 1);
    chk("bp_hit", bp_hit, 1);
    chk("bp_pc", pc_m, 5);
    chk("bp_count", cycle_count, 5);
    chk("bp_drain", exp_q.size(), 0);

    // Resume from the breakpoint: runs past address 5
    @(negedge clk);
    k = cyc;
    j = first_tick(k, div_m);
    run_btn = 1'b1;
    exp_q.push_back(j + 1);
    exp_q.push_back(j + 9);
    exp_q.push_back(j + 17);
    @(negedge clk);
    run_btn = 1'b0;
    @(negedge clk);
    #1;
    chk("resume_bp_hit", bp_hit, 0);
    chk("resume_state", state, 2);
    wait_neg(j + 18 - (k + 2));
    halt_sw = 1'b1;
    wait_neg(3);
    #1;
    $display("bp resume: pc=%0d bp_hit=%0d count=%0d", pc_m, bp_hit, cycle_count);
    chk("resume_pc", pc_m, 8);
    chk("resume_hit_after", bp_hit, 0);
    chk("resume_count", cycle_count, 8);
    chk("resume_drain", exp_q.size(), 0);
    halt_sw = 1'b0;
    bp_enable = 1'b0;

    // Slow mode: one strobe per 8 cycles, then every cycle once slow_sw drops
    do_reset();
    @(negedge clk);
    k = cyc;
    j = first_tick(k, div_m);
    run_btn = 1'b1;
    exp_q.push_back(j + 1);
    exp_q.push_back(j + 9);
    exp_q.push_back(j + 17);
    for (int i = 18; i <= 22; i++) exp_q.push_back(j + i);
    @(negedge clk);
    run_btn = 1'b0;
    wait_neg(j + 17 - (k + 1));
    slow_sw = 1'b0;
    wait_neg(5);
    halt_sw = 1'b1;
    wait_neg(3);
    #1;
    $display("slow mode: count=%0d state=%0d", cycle_count, state);
    chk("slow_count", cycle_count, 8);
    chk("slow_state", state, 1);
    chk("slow_drain", exp_q.size(), 0);
    halt_sw = 1'b0;

    // Asynchronous reset in the middle of a run
    do_reset();
    @(negedge clk);
    k = cyc;
    run_btn = 1'b1;
    for (int i = 2; i <= 6; i++) exp_q.push_back(k + i);
    @(negedge clk);
    run_btn = 1'b0;
    wait_neg(5);
    #2;
    rst = 1'b1;
    pc_clr = 1'b1;
    #1;
    $display("async rst: clk_en=%0d cpu_rst=%0d count=%0d state=%0d", cpu_clk_en, cpu_rst, cycle_count, state);
    chk("arst_clk_en", cpu_clk_en, 0);
    chk("arst_cpu_rst", cpu_rst, 1);
    chk("arst_count", cycle_count, 0);
    chk("arst_state", state, 0);
    chk("arst_drain", exp_q.size(), 0);
    wait_neg(2);
    release_seq();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
